// File: rtl/adder6_reg.sv
// Registered 6-bit unsigned adder: ripple-carry core feeding a 7-bit output register.
// The sum is qualified by out_valid one clock after the operands arrive.
module adder6_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [5:0] a,
  input  logic [5:0] b,
  output logic [6:0] sum,
  output logic       out_valid
);

  logic [6:0] carry;
  logic [5:0] sum_bits;
  logic [6:0] sum_d, sum_q;
  logic       out_valid_d, out_valid_q;

  // Ripple-carry chain; carry[0] is tied low and carry[6] becomes the sum MSB.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    carry    = '0;
    sum_bits = '0;
    for (int i = 0; i < 6; i++) begin
      sum_bits[i]  = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  // Only a valid beat reaches the register, so X operands on idle cycles never land in sum.
  always_comb begin
    sum_d       = sum_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = {carry[6], sum_bits};
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sum_q       <= 7'd0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder6_reg.sv
// Scoreboard bench for adder6_reg: stimulus pushes expected sums tagged with their
// due cycle; a negedge monitor pops and compares whenever out_valid is seen.
`timescale 1ns/1ps
module tb_adder6_reg;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [5:0] a;
  logic [5:0] b;
  logic [6:0] sum;
  logic       out_valid;

  typedef struct {
    logic [6:0] sum;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cycle_cnt = 0;
  int   total     = 0;
  int   bad       = 0;

  adder6_reg dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt = cycle_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // Inputs change 1ns after the falling edge; the next rising edge captures them.
  task automatic apply(input logic r, input logic iv, input logic [5:0] aa,
                       input logic [5:0] bb, input logic [6:0] exp);
    exp_t e;
    #1;
    rst      = r;
    in_valid = iv;
    a        = aa;
    b        = bb;
    if (!r && iv) begin
      e.sum = exp;
      e.cyc = cycle_cnt + 1;
      sb.push_back(e);
    end
  endtask

  // Monitor: a presented result must match the oldest expectation and arrive on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", {25'd0, sum}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("sb_sum", {25'd0, sum}, {25'd0, e.sum});
        check("sb_latency", cycle_cnt, e.cyc);
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cycle_cnt) begin
      e = sb.pop_front();
      check("sb_missing_out_valid", {31'd0, out_valid}, 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 6'd63;
    b        = 6'd63;

    // Two reset cycles with valid operands present: everything stays cleared.
    @(negedge clk);
    check("reset1_sum", {25'd0, sum}, 32'd0);
    check("reset1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("reset2_sum", {25'd0, sum}, 32'd0);
    check("reset2_valid", {31'd0, out_valid}, 32'd0);
    apply(1'b0, 1'b0, 6'd5, 6'd9, 7'd0);
    @(negedge clk);
    check("post_reset_sum", {25'd0, sum}, 32'd0);
    check("post_reset_valid", {31'd0, out_valid}, 32'd0);

    // Basic sequence, back-to-back.
    apply(1'b0, 1'b1, 6'd0, 6'd0, 7'd0);
    @(negedge clk);
    apply(1'b0, 1'b1, 6'd3, 6'd5, 7'd8);
    @(negedge clk);
    apply(1'b0, 1'b1, 6'd10, 6'd7, 7'd17);
    @(negedge clk);

    // Hold: idle cycle keeps 17, including with unknown operands.
    apply(1'b0, 1'b0, 6'd5, 6'd9, 7'd0);
    @(negedge clk);
    check("hold_sum", {25'd0, sum}, 32'd17);
    check("hold_valid", {31'd0, out_valid}, 32'd0);
    apply(1'b0, 1'b0, 6'bx, 6'bx, 7'd0);
    @(negedge clk);
    check("hold_x_sum", {25'd0, sum}, 32'd17);
    check("hold_x_valid", {31'd0, out_valid}, 32'd0);

    apply(1'b0, 1'b1, 6'd8, 6'd3, 7'd11);
    @(negedge clk);

    // Carry propagation cases.
    apply(1'b0, 1'b1, 6'd63, 6'd1, 7'd64);
    @(negedge clk);
    apply(1'b0, 1'b1, 6'd63, 6'd63, 7'd126);
    @(negedge clk);
    apply(1'b0, 1'b1, 6'd32, 6'd32, 7'd64);
    @(negedge clk);
    apply(1'b0, 1'b1, 6'd0, 6'd63, 7'd63);
    @(negedge clk);

    // Reset wins over a valid (10,7): the 17 must never appear.
    apply(1'b1, 1'b1, 6'd10, 6'd7, 7'd17);
    @(negedge clk);
    check("mid_reset_sum", {25'd0, sum}, 32'd0);
    check("mid_reset_valid", {31'd0, out_valid}, 32'd0);
    apply(1'b0, 1'b0, 6'd0, 6'd0, 7'd0);
    @(negedge clk);
    check("after_mid_reset_sum", {25'd0, sum}, 32'd0);
    check("after_mid_reset_valid", {31'd0, out_valid}, 32'd0);

    // Exhaustive stream of all operand pairs.
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 64; j++) begin
        apply(1'b0, 1'b1, 6'(i), 6'(j), 7'(i + j));
        @(negedge clk);
      end
    end
    apply(1'b0, 1'b0, 6'd0, 6'd0, 7'd0);
    @(negedge clk);
    check("final_sum", {25'd0, sum}, 32'd126);
    check("final_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
